// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: 2-entry elastic buffer (output + skid register) with
// a registered ready and a condition-code register updated in accept order.
module ex_mem_stage #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_alu_out,
   input  logic              ex_carry,
   input  logic [2:0]        ex_alu_ctrl,
   input  logic [2:0]        ex_rdst,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] mem_alu_out,
   output logic [2:0]        mem_rdst,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [2:0]        ccr
);

   localparam int PL_W = 2*DATA_W + 6;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PL_W-1:0]  r_out_pl;
   logic [PL_W-1:0]  r_skid_pl;
   logic [PL_W-1:0]  w_in_pl;
   logic [2:0]       r_ccr;
   logic             w_accept;
   logic             w_taken;
   logic             w_ld_out_in;
   logic             w_ld_out_skid;
   logic             w_ld_skid;

   assign w_in_pl  = {ex_alu_out, ex_rdst, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data};
   assign ex_ready  = (r_state != TWO);
   assign mem_valid = (r_state != EMPTY);
   assign w_accept  = ex_valid && ex_ready;
   assign w_taken   = mem_valid && mem_ready;

   assign {mem_alu_out, mem_rdst, mem_reg_write, mem_mem_read, mem_mem_write, mem_store_data} = r_out_pl;
   assign ccr = r_ccr;

   always_comb begin
      w_state_nxt   = r_state;
      w_ld_out_in   = 1'b0;
      w_ld_out_skid = 1'b0;
      w_ld_skid     = 1'b0;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ONE;
                  w_ld_out_in = 1'b1;
               end
            end
            ONE: begin
               if (w_accept && !w_taken) begin
                  w_state_nxt = TWO;
                  w_ld_skid   = 1'b1;
               end else if (!w_accept && w_taken) begin
                  w_state_nxt = EMPTY;
               end else if (w_accept && w_taken) begin
                  w_ld_out_in = 1'b1;
               end
            end
            TWO: begin
               if (w_taken) begin
                  w_state_nxt   = ONE;
                  w_ld_out_skid = 1'b1;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= EMPTY;
         r_out_pl  <= '0;
         r_skid_pl <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld_out_in)   r_out_pl  <= w_in_pl;
         if (w_ld_out_skid) r_out_pl  <= r_skid_pl;
         if (w_ld_skid)     r_skid_pl <= w_in_pl;
      end
   end

   // Flags follow accept order, so a flushed (dropped) accept leaves them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ccr <= 3'b000;
      end else if (w_accept && !flush) begin
         case (ex_alu_ctrl)
            3'b001: r_ccr <= {ex_alu_out[DATA_W-1], ex_carry, (ex_alu_out == '0)};
            3'b010: r_ccr <= {ex_alu_out[DATA_W-1], r_ccr[1], (ex_alu_out == '0)};
            default: r_ccr <= r_ccr;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic against a
// queue-based reference of the two-entry buffer and the condition codes.
module tb_ex_mem_stage;

   typedef struct packed {
      logic [15:0] alu;
      logic [2:0]  rdst;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [15:0] sd;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [15:0] ex_alu_out;
   logic        ex_carry;
   logic [2:0]  ex_alu_ctrl;
   logic [2:0]  ex_rdst;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [15:0] ex_store_data;
   logic        flush;
   logic        mem_valid;
   logic        mem_ready;
   logic [15:0] mem_alu_out;
   logic [2:0]  mem_rdst;
   logic        mem_reg_write;
   logic        mem_mem_read;
   logic        mem_mem_write;
   logic [15:0] mem_store_data;
   logic [2:0]  ccr;

   int n_checks = 0;
   int n_err    = 0;

   ent_t       m_q[$];
   logic [2:0] m_ccr;
   logic [2:0] saved_ccr;

   ex_mem_stage #(.DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_out(ex_alu_out), .ex_carry(ex_carry), .ex_alu_ctrl(ex_alu_ctrl),
      .ex_rdst(ex_rdst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_alu_out(mem_alu_out),
      .mem_rdst(mem_rdst), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data), .ccr(ccr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ent_t dut_out();
      ent_t e;
      e = {mem_alu_out, mem_rdst, mem_reg_write, mem_mem_read, mem_mem_write, mem_store_data};
      return e;
   endfunction

   task automatic cmp_model();
      chk("mem_valid", 64'(mem_valid), 64'(m_q.size() != 0));
      chk("ex_ready", 64'(ex_ready), 64'(m_q.size() < 2));
      chk("ccr", 64'(ccr), 64'(m_ccr));
      if (m_q.size() != 0) chk("payload", 64'(dut_out()), 64'(m_q[0]));
   endtask

   // Drive one cycle's inputs, advance the reference by one edge, then compare.
   task automatic step(input logic v, input logic [2:0] ctrl, input logic [15:0] alu,
                       input logic carry, input ent_t side, input logic rdy, input logic fl);
      ent_t e;
      logic accept;
      logic taken;
      e = side;
      e.alu = alu;
      ex_valid = v; ex_alu_ctrl = ctrl; ex_alu_out = alu; ex_carry = carry;
      ex_rdst = e.rdst; ex_reg_write = e.rw; ex_mem_read = e.mr; ex_mem_write = e.mw;
      ex_store_data = e.sd; mem_ready = rdy; flush = fl;
      accept = v && (m_q.size() < 2);
      taken  = (m_q.size() != 0) && rdy;
      if (fl) begin
         m_q.delete();
      end else begin
         if (taken) void'(m_q.pop_front());
         if (accept) begin
            m_q.push_back(e);
            if (ctrl == 3'd1)
               m_ccr = {alu >= 16'h8000, carry, alu == 16'd0};
            else if (ctrl == 3'd2)
               m_ccr = {alu >= 16'h8000, m_ccr[1], alu == 16'd0};
         end
      end
      @(negedge clk);
      cmp_model();
   endtask

   function automatic ent_t rnd_side();
      ent_t e;
      e.alu = 16'($urandom);
      e.rdst = 3'($urandom);
      e.rw = 1'($urandom);
      e.mr = 1'($urandom);
      e.mw = 1'($urandom);
      e.sd = 16'($urandom);
      return e;
   endfunction

   task automatic idle(input logic rdy);
      step(1'b0, 3'd0, 16'd0, 1'b0, '0, rdy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; ex_alu_out = '0; ex_carry = 1'b0; ex_alu_ctrl = '0;
      ex_rdst = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_store_data = '0; flush = 1'b0; mem_ready = 1'b0;
      m_ccr = 3'b000;
      #12;
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_ex_ready", 64'(ex_ready), 64'd1);
      chk("rst_ccr", 64'(ccr), 64'd0);
      chk("rst_payload", 64'(dut_out()), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-result add straight out of reset
      step(1'b1, 3'd1, 16'h0000, 1'b1, rnd_side(), 1'b1, 1'b0);
      chk("r32_valid", 64'(mem_valid), 64'd1);
      chk("r32_alu", 64'(mem_alu_out), 64'h0000);
      chk("r32_ccr", 64'(ccr), 64'b011);

      step(1'b1, 3'd2, 16'hFFFF, 1'b0, rnd_side(), 1'b1, 1'b0);
      chk("r34_ccr", 64'(ccr), 64'b110);
      idle(1'b1);
      idle(1'b1);

      // Two accepts under backpressure, then drain in order
      step(1'b1, 3'd1, 16'h1234, 1'b0, rnd_side(), 1'b0, 1'b0);
      step(1'b1, 3'd1, 16'h8000, 1'b0, rnd_side(), 1'b0, 1'b0);
      chk("r33_full", 64'(ex_ready), 64'd0);
      chk("r33_A", 64'(mem_alu_out), 64'h1234);
      step(1'b1, 3'd1, 16'h5555, 1'b1, rnd_side(), 1'b0, 1'b0);
      chk("r33_hold", 64'(mem_alu_out), 64'h1234);
      idle(1'b1);
      chk("r33_B", 64'(mem_alu_out), 64'h8000);
      chk("r33_ccr", 64'(ccr), 64'b100);
      idle(1'b1);
      chk("r33_empty", 64'(mem_valid), 64'd0);

      // Flush while full, with a same-cycle add that must not touch ccr
      step(1'b1, 3'd2, 16'h0F0F, 1'b0, rnd_side(), 1'b0, 1'b0);
      step(1'b1, 3'd1, 16'h7000, 1'b1, rnd_side(), 1'b0, 1'b0);
      saved_ccr = ccr;
      step(1'b1, 3'd1, 16'h0000, 1'b0, rnd_side(), 1'b0, 1'b1);
      chk("r35_valid", 64'(mem_valid), 64'd0);
      chk("r35_ready", 64'(ex_ready), 64'd1);
      chk("r35_ccr", 64'(ccr), 64'(saved_ccr));

      // Flush in the same cycle as a downstream transfer
      step(1'b1, 3'd3, 16'h0042, 1'b0, rnd_side(), 1'b1, 1'b0);
      step(1'b1, 3'd1, 16'h0001, 1'b0, rnd_side(), 1'b1, 1'b1);
      chk("r28_valid", 64'(mem_valid), 64'd0);

      // Back-to-back streaming
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), rnd_side(), 1'b1, 1'b0);
         chk("r36_ready", 64'(ex_ready), 64'd1);
         chk("r36_valid", 64'(mem_valid), 64'd1);
      end
      idle(1'b1);

      // Asynchronous reset while holding two entries
      step(1'b1, 3'd1, 16'h8001, 1'b1, rnd_side(), 1'b0, 1'b0);
      step(1'b1, 3'd1, 16'h8002, 1'b1, rnd_side(), 1'b0, 1'b0);
      chk("r37_full", 64'(ex_ready), 64'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("r37_valid", 64'(mem_valid), 64'd0);
      chk("r37_ccr", 64'(ccr), 64'd0);
      chk("r37_ready", 64'(ex_ready), 64'd1);
      chk("r37_payload", 64'(dut_out()), 64'd0);
      m_q.delete();
      m_ccr = 3'b000;
      ex_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 3'd1, 16'h0000, 1'b0, rnd_side(), 1'b0, 1'b0);
      chk("r31_first", 64'(mem_valid), 64'd1);

      for (int i = 0; i < 500; i++) begin
         step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom), rnd_side(), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width of ALU result and store data.
REQ-002 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ex_valid  input  1  execute stage presents an instruction.
REQ-005 SHALL have ex_ready  output  1  stage can accept this cycle.
REQ-006 SHALL have ex_alu_out  input  DATA_W  ALU result.
REQ-007 SHALL have ex_carry  input  1  ALU carry-out (flag bit 1).
REQ-008 SHALL have ex_alu_ctrl  input  3  ALU op: 000 nop, 001 add, 010 not, 011 pass in1, 100 pass in2.
REQ-009 SHALL have ex_rdst  input  3  destination register index.
REQ-010 SHALL have ex_reg_write, ex_mem_read, ex_mem_write  input  1 each  control bits.
REQ-011 SHALL have ex_store_data  input  DATA_W  store operand.
REQ-012 SHALL have flush  input  1  synchronous discard of all held instructions.
REQ-013 SHALL have mem_valid  output  1  and mem_ready  input  1  downstream handshake.
REQ-014 SHALL have mem_alu_out, mem_rdst, mem_reg_write, mem_mem_read, mem_mem_write, mem_store_data  outputs, widths as REQ-006..011, registered payload.
REQ-015 SHALL have ccr  output  3  condition code register {N,C,Z} = {bit2,bit1,bit0}.

Function
REQ-016 SHALL transfer input when ex_valid && ex_ready, and output when mem_valid && mem_ready.
REQ-017 SHALL hold a 2-entry buffer (output register + skid register) controlled by states EMPTY, ONE, TWO.
REQ-018 SHALL drive ex_ready = (state != TWO), decoded from state register only (no combinational path from mem_ready).
REQ-019 SHALL drive mem_valid = (state != EMPTY); payload outputs always come from the output register.
REQ-020 EMPTY: accept -> ONE, payload into output register.
REQ-021 ONE: accept && !out_taken -> TWO, payload into skid; !accept && out_taken -> EMPTY; accept && out_taken -> ONE, payload into output register.
REQ-022 TWO: out_taken -> ONE, skid copied to output register; else hold; no accept possible.
REQ-023 SHALL keep payload outputs stable while mem_valid && !mem_ready.
REQ-024 Latency: instruction accepted on edge N SHALL appear on outputs after edge N (mem_valid high in cycle N+1) when state was EMPTY.
REQ-025 SHALL preserve program order; skid entry always leaves after output entry.
REQ-026 CCR SHALL update on the accept edge, in accept order: 001 -> Z=(ex_alu_out==0), N=ex_alu_out[DATA_W-1], C=ex_carry; 010 -> Z,N updated, C held; 000/011/100/101-111 -> all held.
REQ-027 flush SHALL force state EMPTY on the next edge, dropping both entries and any same-cycle accept; a flushed-cycle accept SHALL NOT update ccr; ccr otherwise retained.
REQ-028 flush && out_taken same cycle: transfer counts as completed downstream, state still EMPTY.
REQ-029 Non-accepted cycles SHALL not change ccr or buffered payload.

Reset
REQ-030 rst_n low SHALL immediately set state EMPTY, ccr=000, all payload registers 0, mem_valid=0, ex_ready=1.
REQ-031 Reset mid-operation SHALL discard buffered instructions with no completed transfer; first accept allowed on first edge with rst_n high.

Verification
REQ-032 Reset release, ex_valid=1 add alu_out=0x0000 carry=1, mem_ready=1 -> next cycle mem_valid=1, mem_alu_out=0x0000, ccr=011.
REQ-033 mem_ready=0, two accepts (A=0x1234, B=0x8000 add, carry=0) -> ex_ready=0 after 2nd; then mem_ready=1 -> A, then B out in order; ccr=100.
REQ-034 not op result 0xFFFF after ccr=011 -> ccr=110 (C held).
REQ-035 Full buffer + flush=1 with ex_valid=1 add 0x0000 -> next cycle mem_valid=0, ex_ready=1, ccr unchanged.
REQ-036 Streaming 16 back-to-back ops with mem_ready=1 -> one output per cycle, ex_ready never 0.
REQ-037 rst_n asserted while state TWO -> mem_valid=0, ccr=000 without clock edge.
